// File: rtl/serial_nibble_adder_ctrl_pkg.sv
// serial_nibble_adder_ctrl_pkg: shared FSM state encodings, nibble width and counter-width helper
package serial_nibble_adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  function automatic int cnt_w(input int nib);
    return nib > 1 ? $clog2(nib) : 1;
  endfunction
endpackage

// File: rtl/serial_nibble_adder_ctrl_if.sv
// serial_nibble_adder_ctrl_if: start/done handshakes, operands and result/flags; master = requester, slave = controller
interface serial_nibble_adder_ctrl_if #(parameter int WIDTH = 16) ();
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  modport master (
    output start_valid, a, b, sub, done_ready,
    input  start_ready, done_valid, result, carry_out, overflow, busy
  );
  modport slave (
    input  start_valid, a, b, sub, done_ready,
    output start_ready, done_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_nibble_adder_ctrl_adder.sv
// FourBitRippleCarryAdder: 4-bit ripple-carry adder; A/B/c in, S/c4 out
module FourBitRippleCarryAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c,
  output logic [3:0] S,
  output logic       c4
);
  logic [4:0] cy;
  always_comb begin
    cy = '0;
    S  = '0;
    cy[0] = c;
    for (int i = 0; i < 4; i++) begin
      S[i]    = A[i] ^ B[i] ^ cy[i];
      cy[i+1] = (A[i] & B[i]) | (cy[i] & (A[i] ^ B[i]));
    end
  end
  assign c4 = cy[4];
endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// serial_nibble_adder_ctrl: WIDTH-bit add/sub one nibble per clock; clk, rst, bus (slave: start/done handshakes, a, b, sub, result, carry_out, overflow, busy)
module serial_nibble_adder_ctrl
  import serial_nibble_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  serial_nibble_adder_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_w(NIB);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, sa_q, sb_q, cout_q, ovf_q, srdy_q, dval_q, busy_q;
  logic [3:0]       s;
  logic             c4, last;
  FourBitRippleCarryAdder u_add (
    .A (a_q[3:0]),
    .B (b_q[3:0]),
    .c (carry_q),
    .S (s),
    .c4(c4)
  );
  assign last = cnt_q == CW'(NIB - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      srdy_q  <= 1'b1;
      dval_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_valid) begin
          // subtraction is A + ~B + 1, the +1 entering as the first carry-in
          a_q     <= bus.a;
          b_q     <= bus.b ^ {WIDTH{bus.sub}};
          carry_q <= bus.sub;
          cnt_q   <= '0;
          sa_q    <= bus.a[WIDTH-1];
          sb_q    <= bus.b[WIDTH-1] ^ bus.sub;
          state_q <= ST_RUN;
          srdy_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
        ST_RUN: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          // sum nibble enters at the top; the low WIDTH bits of the shifted concat also cover WIDTH == 4
          res_q   <= WIDTH'({s, res_q} >> NIBBLE_W);
          carry_q <= c4;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q <= ST_DONE;
            dval_q  <= 1'b1;
            cout_q  <= c4;
            ovf_q   <= (sa_q == sb_q) && (s[3] != sa_q);
          end
        end
        ST_DONE: if (bus.done_ready) begin
          state_q <= ST_IDLE;
          dval_q  <= 1'b0;
          busy_q  <= 1'b0;
          srdy_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          dval_q  <= 1'b0;
          busy_q  <= 1'b0;
          srdy_q  <= 1'b1;
        end
      endcase
    end
  end
  assign bus.start_ready = srdy_q;
  assign bus.done_valid  = dval_q;
  assign bus.busy        = busy_q;
  assign bus.result      = res_q;
  assign bus.carry_out   = cout_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// tb_serial_nibble_adder_ctrl: directed vectors, cycle-level reference model and literal checks for the serial nibble adder controller
module tb_serial_nibble_adder_ctrl;
  localparam int NIB16 = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  serial_nibble_adder_ctrl_if #(.WIDTH(16)) bus ();
  serial_nibble_adder_ctrl_if #(.WIDTH(4))  bus4 ();
  serial_nibble_adder_ctrl #(.WIDTH(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_nibble_adder_ctrl #(.WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  int          t = -1;
  logic        armed = 1'b0;
  logic        after_rst = 1'b0;
  logic [15:0] er;
  logic        ec, eo;
  int          cyc = 0;
  int          acc_q[$];
  always @(negedge clk) begin
    int sa, sb, sr;
    cyc++;
    if (armed && !rst) begin
      check("m_start_ready", 32'(bus.start_ready), 32'(t < 0));
      check("m_busy", 32'(bus.busy), 32'(t >= 0));
      check("m_done_valid", 32'(bus.done_valid), 32'(t >= NIB16));
      if (after_rst) begin
        check("m_rst_result", 32'(bus.result), 32'h0);
        check("m_rst_carry", 32'(bus.carry_out), 32'h0);
        check("m_rst_ovf", 32'(bus.overflow), 32'h0);
      end
      if (t >= NIB16) begin
        check("m_result", 32'(bus.result), 32'(er));
        check("m_carry", 32'(bus.carry_out), 32'(ec));
        check("m_ovf", 32'(bus.overflow), 32'(eo));
      end
    end
    after_rst = rst;
    if (rst) begin
      t = -1;
      armed = 1'b1;
    end else if (t < 0) begin
      if (bus.start_valid) begin
        sa = int'($signed(bus.a));
        sb = int'($signed(bus.b));
        sr = bus.sub ? sa - sb : sa + sb;
        er = bus.sub ? bus.a - bus.b : bus.a + bus.b;
        ec = bus.sub ? (bus.a >= bus.b) : ((int'(bus.a) + int'(bus.b)) > 65535);
        eo = (sr > 32767) || (sr < -32768);
        t  = 0;
        acc_q.push_back(cyc);
      end
    end else if (t < NIB16) begin
      t++;
    end else if (bus.done_ready) begin
      t = -1;
    end
  end
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic dr,
                    output logic [15:0] r, output logic co, output logic ov, output int lat);
    int k;
    @(posedge clk);
    #2;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    bus.done_ready = dr;
    bus.start_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.start_ready && k < 20);
    @(posedge clk);
    #2;
    bus.start_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.sub = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.done_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 20) check("timeout16", 32'd1, 32'd0);
    r = bus.result;
    co = bus.carry_out;
    ov = bus.overflow;
  endtask
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [3:0] r, output logic co, output logic ov, output int lat);
    @(posedge clk);
    #2;
    bus4.a = a;
    bus4.b = b;
    bus4.sub = s;
    bus4.done_ready = 1'b1;
    bus4.start_valid = 1'b1;
    @(posedge clk);
    #2;
    bus4.start_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus4.done_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 20) check("timeout4", 32'd1, 32'd0);
    r = bus4.result;
    co = bus4.carry_out;
    ov = bus4.overflow;
  endtask
  task automatic expect16(input string nm, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] xr, input logic xc, input logic xo);
    logic [15:0] r;
    logic        co, ov;
    int          lat;
    op(a, b, s, 1'b1, r, co, ov, lat);
    check({nm, "_result"}, 32'(r), 32'(xr));
    check({nm, "_carry"}, 32'(co), 32'(xc));
    check({nm, "_ovf"}, 32'(ov), 32'(xo));
    check({nm, "_lat"}, 32'(lat), 32'd4);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] r;
    logic [3:0]  r4;
    logic        co, ov;
    int          lat;
    bus.start_valid = 1'b0;
    bus.done_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus4.start_valid = 1'b0;
    bus4.done_ready = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.sub = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_start_ready", 32'(bus.start_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done_valid", 32'(bus.done_valid), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    expect16("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    expect16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    expect16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    expect16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op(16'h1234, 16'h0001, 1'b0, 1'b0, r, co, ov, lat);
    check("bp_result", 32'(r), 32'h1235);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      bus.start_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(negedge clk);
      check("bp_done_valid", 32'(bus.done_valid), 32'd1);
      check("bp_start_ready", 32'(bus.start_ready), 32'd0);
      check("bp_hold_result", 32'(bus.result), 32'h1235);
      check("bp_hold_carry", 32'(bus.carry_out), 32'd0);
    end
    @(posedge clk);
    #2;
    bus.start_valid = 1'b0;
    bus.done_ready = 1'b1;
    @(negedge clk);
    check("bp_still_done", 32'(bus.done_valid), 32'd1);
    @(negedge clk);
    check("bp_idle_ready", 32'(bus.start_ready), 32'd1);
    check("bp_idle_valid", 32'(bus.done_valid), 32'd0);
    @(posedge clk);
    #2;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.sub = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    check("midrst_done_valid", 32'(bus.done_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_carry", 32'(bus.carry_out), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_done", 32'(bus.done_valid), 32'd0);
    expect16("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    acc_q.delete();
    bus.a = 16'h0100;
    bus.b = 16'h0011;
    bus.sub = 1'b0;
    bus.done_ready = 1'b1;
    bus.start_valid = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    bus.start_valid = 1'b0;
    repeat (8) @(posedge clk);
    check("b2b_count", 32'(acc_q.size() >= 3), 32'd1);
    for (int i = 1; i < acc_q.size(); i++) check("b2b_interval", 32'(acc_q[i] - acc_q[i-1]), 32'd6);
    op4(4'hF, 4'h1, 1'b0, r4, co, ov, lat);
    check("w4_result", 32'(r4), 32'h0);
    check("w4_carry", 32'(co), 32'd1);
    check("w4_ovf", 32'(ov), 32'd0);
    check("w4_lat", 32'(lat), 32'd1);
    op4(4'h7, 4'h1, 1'b0, r4, co, ov, lat);
    check("w4_ovf_result", 32'(r4), 32'h8);
    check("w4_ovf_flag", 32'(ov), 32'd1);
    op4(4'h3, 4'h5, 1'b1, r4, co, ov, lat);
    check("w4_sub_result", 32'(r4), 32'hE);
    check("w4_sub_carry", 32'(co), 32'd0);
    check("w4_sub_ovf", 32'(ov), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
